// File: rtl/internal_paths_pkg.sv
// Shared constants, stage record and helpers for the internal_paths_pipe slice.
package internal_paths_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;

    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] data;
    } stage_t;

    // Index widths never collapse to zero bits, even for tiny ranges.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = $unsigned($clog2(n));
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/internal_paths_stage.sv
// One valid+data register of the elastic pipe; loads from its predecessor when
// the advance chain lets it move.
module internal_paths_stage
    import internal_paths_pkg::*;
#(
    parameter type slot_t = stage_t
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  adv,
    input  logic  flush,
    input  slot_t prev,
    output slot_t q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
        end else if (adv) begin
            q.valid <= prev.valid;
            // Data only follows real words so bubbles leave the last value in place.
            if (prev.valid) begin
                q.data <= prev.data;
            end
        end
    end

endmodule

// File: rtl/internal_paths_pipe.sv
// Parametrised elastic register pipe with ready/valid ends and a stage tap port.
// Optional occupancy/full outputs are built when INTERNAL_PATHS_PIPE_OCC_EN is defined.
module internal_paths_pipe
    import internal_paths_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned TAP_W = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [WIDTH-1:0] tap_data,
    output logic             tap_valid
`ifdef INTERNAL_PATHS_PIPE_OCC_EN
    ,
    output logic [clog2_min1(DEPTH+1)-1:0] occupancy,
    output logic                           full
`endif
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } pipe_stage_t;

    pipe_stage_t      st   [DEPTH];
    pipe_stage_t      stin [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic             blocked;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign stin[g] = '{valid: in_valid, data: in_data};
        end else begin : g_link
            assign stin[g] = st[g-1];
        end

        internal_paths_stage #(
            .slot_t (pipe_stage_t)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (adv[g]),
            .flush (flush),
            .prev  (stin[g]),
            .q     (st[g])
        );

        assign v[g] = st[g].valid;
    end

    // Ripple form of adv[i] = adv[i+1] | ~v[i], evaluated from the output end;
    // a stage is blocked only if it and everything downstream are full and stalled.
    always_comb begin
        adv     = '0;
        blocked = ~out_ready;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            blocked             = blocked & v[DEPTH-1-k];
            adv[DEPTH-1-k]      = ~blocked;
        end
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = st[DEPTH-1].data;

    always_comb begin
        tap_data  = '0;
        tap_valid = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (32'(tap_sel) == i) begin
                tap_data  = st[i].data;
                tap_valid = st[i].valid;
            end
        end
    end

`ifdef INTERNAL_PATHS_PIPE_OCC_EN
    localparam int unsigned OCC_W = clog2_min1(DEPTH + 1);

    logic [OCC_W-1:0] occ;

    // Popcount of the registered valid bits, so it tracks the state after each edge.
    always_comb begin
        occ = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ = occ + OCC_W'(v[i]);
        end
    end

    assign occupancy = occ;
    assign full      = (occ == OCC_W'(DEPTH));
`endif

endmodule

// File: tb/tb_internal_paths_pipe.sv
// Directed self-checking bench for internal_paths_pipe (WIDTH=8, DEPTH=4).
module tb_internal_paths_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       flush;
    logic [1:0] tap_sel;
    logic [7:0] tap_data;
    logic       tap_valid;
`ifdef INTERNAL_PATHS_PIPE_OCC_EN
    logic [2:0] occupancy;
    logic       full;
`endif

    int tests;
    int fails;

    internal_paths_pipe #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .tap_sel   (tap_sel),
        .tap_data  (tap_data),
        .tap_valid (tap_valid)
`ifdef INTERNAL_PATHS_PIPE_OCC_EN
        ,
        .occupancy (occupancy),
        .full      (full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        out_ready = 1'b0;
        flush     = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++;
        if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef INTERNAL_PATHS_PIPE_OCC_EN
        tests++;
        if (occupancy !== 3'd0 || full !== 1'b0) begin
            fails++; $display("FAIL reset_occ: got occ=%0d full=%b want 0/0", occupancy, full);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            tap_sel = 2'(i);
            #1;
            tests++;
            if (tap_valid !== 1'b0 || tap_data !== 8'h00) begin
                fails++; $display("FAIL reset_tap%0d: got v=%b d=%h want 0/00", i, tap_valid, tap_data);
            end
        end
        tick();
        tap_sel = 2'd0;
        flush   = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_flush_in_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0;
    endtask

    task automatic test_streaming();
        logic [7:0] pat [3];
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 3);
            in_data  = (c < 3) ? pat[c] : 8'h00;
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready c%0d: got %b want 1", c, in_ready); end
            tests++;
            if (out_valid !== (c >= 4 && c <= 6)) begin
                fails++; $display("FAIL stream_out_valid c%0d: got %b want %b", c, out_valid, (c >= 4 && c <= 6));
            end
            if (c >= 4 && c <= 6) begin
                tests++;
                if (out_data !== pat[c-4]) begin
                    fails++; $display("FAIL stream_out_data c%0d: got %h want %h", c, out_data, pat[c-4]);
                end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_fill_stall();
        int         k;
        logic       exp_ir;
        logic       exp_ov;
        logic [7:0] exp_od;
        k = 0;
        for (int c = 0; c < 13; c++) begin
            out_ready = (c >= 6);
            in_valid  = (k < 6);
            in_data   = 8'hA0 + 8'(k);
            exp_ir    = (c < 4) || (c >= 6);
            exp_ov    = (c >= 4) && (c <= 11);
            exp_od    = (c <= 6) ? 8'hA0 : 8'hA0 + 8'(c - 6);
            @(negedge clk);
            tests++;
            if (in_ready !== exp_ir) begin fails++; $display("FAIL fill_in_ready c%0d: got %b want %b", c, in_ready, exp_ir); end
            tests++;
            if (out_valid !== exp_ov) begin fails++; $display("FAIL fill_out_valid c%0d: got %b want %b", c, out_valid, exp_ov); end
            if (exp_ov) begin
                tests++;
                if (out_data !== exp_od) begin fails++; $display("FAIL fill_out_data c%0d: got %h want %h", c, out_data, exp_od); end
            end
`ifdef INTERNAL_PATHS_PIPE_OCC_EN
            if (c == 5) begin
                tests++;
                if (occupancy !== 3'd4 || full !== 1'b1) begin
                    fails++; $display("FAIL fill_occ: got occ=%0d full=%b want 4/1", occupancy, full);
                end
            end
`endif
            if (in_valid && exp_ir) k++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_bubble();
        logic       ev [4];
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c == 0) || (c == 3);
            in_data  = (c == 0) ? 8'h01 : 8'h02;
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b1) begin fails++; $display("FAIL bubble_in_ready c%0d: got %b want 1", c, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        ev[0] = 1'b0; ev[1] = 1'b0; ev[2] = 1'b1; ev[3] = 1'b1;
        @(negedge clk);
        for (int i = 3; i >= 0; i--) begin
            tap_sel = 2'(i);
            #1;
            tests++;
            if (tap_valid !== ev[i]) begin fails++; $display("FAIL bubble_tap_valid%0d: got %b want %b", i, tap_valid, ev[i]); end
            if (i >= 2) begin
                tests++;
                if (tap_data !== ((i == 3) ? 8'h01 : 8'h02)) begin
                    fails++; $display("FAIL bubble_tap_data%0d: got %h want %h", i, tap_data, (i == 3) ? 8'h01 : 8'h02);
                end
            end
        end
        tick();
        tap_sel   = 2'd0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== (c < 2)) begin fails++; $display("FAIL bubble_drain_valid c%0d: got %b want %b", c, out_valid, (c < 2)); end
            if (c < 2) begin
                tests++;
                if (out_data !== 8'(c + 1)) begin fails++; $display("FAIL bubble_drain_data c%0d: got %h want %h", c, out_data, 8'(c + 1)); end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = (c < 3);
            in_data  = 8'hB1 + 8'(c);
            tick();
        end
        in_valid = 1'b1;
        in_data  = 8'hCC;
        flush    = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'hB1) begin
            fails++; $display("FAIL flush_cycle_out: got v=%b d=%h want 1/b1", out_valid, out_data);
        end
`ifdef INTERNAL_PATHS_PIPE_OCC_EN
        tests++;
        if (occupancy !== 3'd3) begin fails++; $display("FAIL flush_occ_before: got %0d want 3", occupancy); end
`endif
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
`ifdef INTERNAL_PATHS_PIPE_OCC_EN
        tests++;
        if (occupancy !== 3'd0) begin fails++; $display("FAIL flush_occ_after: got %0d want 0", occupancy); end
`endif
        for (int i = 0; i < 4; i++) begin
            tap_sel = 2'(i);
            #1;
            tests++;
            if (tap_valid !== 1'b0) begin fails++; $display("FAIL flush_tap_valid%0d: got %b want 0", i, tap_valid); end
        end
        tick();
        tap_sel   = 2'd0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_leak c%0d: got %b want 0", c, out_valid); end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            in_data  = 8'hD1 + 8'(c);
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hE1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            fails++; $display("FAIL midreset_out: got v=%b d=%h want 0/00", out_valid, out_data);
        end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== (c == 4)) begin fails++; $display("FAIL midreset_valid c%0d: got %b want %b", c, out_valid, (c == 4)); end
            if (c == 4) begin
                tests++;
                if (out_data !== 8'hE1) begin fails++; $display("FAIL midreset_data: got %h want e1", out_data); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = 8'hF0 + 8'(c);
            tick();
        end
        out_ready = 1'b1;
        for (int c = 4; c < 13; c++) begin
            in_valid = (c < 8);
            in_data  = 8'hF0 + 8'(c);
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready c%0d: got %b want 1", c, in_ready); end
            tests++;
            if (out_valid !== (c < 12)) begin fails++; $display("FAIL b2b_out_valid c%0d: got %b want %b", c, out_valid, (c < 12)); end
            if (c < 12) begin
                tests++;
                if (out_data !== 8'hF0 + 8'(c - 4)) begin
                    fails++; $display("FAIL b2b_out_data c%0d: got %h want %h", c, out_data, 8'hF0 + 8'(c - 4));
                end
            end
`ifdef INTERNAL_PATHS_PIPE_OCC_EN
            tests++;
            if (occupancy !== ((c <= 8) ? 3'd4 : 3'(12 - c)) || full !== (c <= 8)) begin
                fails++; $display("FAIL b2b_occ c%0d: got occ=%0d full=%b want %0d/%b",
                                  c, occupancy, full, (c <= 8) ? 4 : 12 - c, (c <= 8));
            end
`endif
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        flush     = 1'b0;
        tap_sel   = 2'd0;
        tick();
        test_reset();
        test_streaming();
        test_fill_stall();
        test_bubble();
        test_flush();
        test_reset_midstream();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
